// File: rtl/uart_host_link.sv
// uart_host_link: host-side 8N1 UART endpoint. Sends operand1 then operand2
// back-to-back on host_tx, then waits for one result byte on host_rx.
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, sampled only while busy=0
//   operand1/operand2  bytes to send, captured at the accepted start
//   host_rx            serial input from the CPU uart_tx (asynchronous)
//   host_tx            serial output to the CPU uart_rx (registered)
//   busy               transaction in progress, through the done cycle
//   done               one-cycle pulse at the end of every transaction
//   result             last successfully received byte
//   err                timeout or framing error on the last transaction
module uart_host_link #(
   parameter int unsigned BAUD_DIV     = 5208,
   parameter int unsigned TIMEOUT_BITS = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] operand1,
   input  logic [7:0] operand2,
   input  logic       host_rx,
   output logic       host_tx,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       err
);

   localparam int unsigned BIT_W    = $clog2(BAUD_DIV);
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(BAUD_DIV / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

   typedef enum logic [2:0] {
      IDLE, TX_OP1, TX_OP2, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE
   } state_t;

   state_t            state;
   logic [BIT_W-1:0]  bit_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [3:0]        bit_idx;
   logic [8:0]        tx_shift;   // remaining data bits plus stop bit
   logic [7:0]        op2;
   logic [7:0]        rx_shift;
   logic              rx_s1, rx_s2, rx_prev;

   // Single-process FSM; every output is a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         to_cnt   <= '0;
         bit_idx  <= '0;
         tx_shift <= '1;
         op2      <= '0;
         rx_shift <= '0;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         host_tx  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= 8'h00;
         err      <= 1'b0;
      end else begin
         rx_s1   <= host_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         done    <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  op2      <= operand2;
                  tx_shift <= {1'b1, operand1};
                  host_tx  <= 1'b0;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  state    <= TX_OP1;
               end
            end

            // Both operand frames share the bit timer and shifter.
            TX_OP1, TX_OP2: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  if (bit_idx == 4'd9) begin
                     bit_idx <= '0;
                     if (state == TX_OP1) begin
                        host_tx  <= 1'b0;
                        tx_shift <= {1'b1, op2};
                        state    <= TX_OP2;
                     end else begin
                        host_tx <= 1'b1;
                        to_cnt  <= '0;
                        state   <= RX_WAIT;
                     end
                  end else begin
                     host_tx  <= tx_shift[0];
                     tx_shift <= {1'b1, tx_shift[8:1]};
                     bit_idx  <= bit_idx + 4'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end

            // Only a synchronized falling edge starts a receive.
            RX_WAIT: begin
               if (to_cnt == TO_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
                  if (rx_prev && !rx_s2) begin
                     bit_cnt <= '0;
                     state   <= RX_START;
                  end
               end
            end

            // Mid start-bit check; a high line means a glitch, and the
            // timeout count is kept so glitches cannot extend the wait.
            RX_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt <= '0;
                  if (rx_s2) begin
                     state <= RX_WAIT;
                  end else begin
                     bit_idx <= '0;
                     state   <= RX_DATA;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end

            RX_DATA: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt  <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (bit_idx == 4'd7) begin
                     bit_idx <= '0;
                     state   <= RX_STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end

            RX_STOP: begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt <= '0;
                  done    <= 1'b1;
                  state   <= DONE;
                  if (rx_s2) begin
                     result <= rx_shift;
                     err    <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end

            // done is high during this state; busy drops as it is left.
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_link.sv
// Self-checking bench for uart_host_link with BAUD_DIV=16, TIMEOUT_BITS=64.
// A behavioural UART model answers on host_rx; expected frames and outcomes
// come from operand/response values, not from the DUT.
module tb_uart_host_link;
   localparam int unsigned B  = 16;
   localparam int unsigned TO = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] operand1 = 8'h00;
   logic [7:0] operand2 = 8'h00;
   logic       host_rx = 1'b1;
   logic       host_tx, busy, done, err;
   logic [7:0] result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Done monitor: records what the DUT showed during each done pulse.
   int         n_done = 0;
   int         done_cyc = 0;
   int         double_done = 0;
   logic       prev_done = 1'b0;
   logic [7:0] cap_result = 8'h00;
   logic       cap_err = 1'b0;
   logic       cap_busy = 1'b0;
   logic       after_busy = 1'b0;

   // Reference: last byte received successfully.
   logic [7:0] model_result = 8'h00;

   uart_host_link #(.BAUD_DIV(B), .TIMEOUT_BITS(TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .operand1(operand1), .operand2(operand2),
      .host_rx(host_rx), .host_tx(host_tx),
      .busy(busy), .done(done), .result(result), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_done <= done;
      if (done) begin
         n_done     <= n_done + 1;
         cap_result <= result;
         cap_err    <= err;
         cap_busy   <= busy;
         done_cyc   <= cyc;
      end
      if (done && prev_done) double_done <= double_done + 1;
      if (prev_done) after_busy <= busy;
   end

   // Called at a negedge with the DUT idle; start is sampled at the next edge.
   task automatic accept_start(input logic [7:0] a, input logic [7:0] b);
      checks++;
      if (busy !== 1'b0 || host_tx !== 1'b1) begin
         errors++;
         $display("FAIL idle_before_start: busy=%b host_tx=%b required 0/1", busy, host_tx);
      end
      operand1 = a;
      operand2 = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL accept: busy=%b err=%b required 1/0", busy, err);
      end
   endtask

   // Checks both frames cycle by cycle; optional start pulses with other
   // operands while busy must not disturb the captured bytes.
   task automatic check_tx(input logic [7:0] a, input logic [7:0] b, input bit disturb);
      logic [19:0] fr;
      logic        exp_bit;
      fr = {1'b1, b, 1'b0, 1'b1, a, 1'b0};
      for (int n = 0; n < 20 * B; n++) begin
         exp_bit = fr[n / B];
         checks++;
         if (host_tx !== exp_bit) begin
            errors++;
            $display("FAIL tx_bit cycle %0d (frame bit %0d): host_tx=%b required %b", n, n / B, host_tx, exp_bit);
         end
         if (n % B == B / 2) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_during_tx cycle %0d: busy=%b required 1", n, busy);
            end
         end
         start = disturb && (n == 37 || n == 250);
         if (start) begin
            operand1 = 8'($urandom);
            operand2 = 8'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (host_tx !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rx_wait_entry: host_tx=%b busy=%b required 1/1", host_tx, busy);
      end
   endtask

   // Behavioural UART transmitter on host_rx.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         host_rx = fr[i];
         repeat (B) @(negedge clk);
      end
      host_rx = 1'b1;
   endtask

   // Sends the response frame and checks the outcome and its timing.
   task automatic rt_finish(input logic [7:0] resp, input logic stop, input int gap);
      int         nd0, f;
      logic [7:0] exp_res;
      logic       exp_err;
      repeat (gap) @(negedge clk);
      nd0 = n_done;
      f = cyc;
      send_frame(resp, stop);
      repeat (4) @(negedge clk);
      exp_err = ~stop;
      exp_res = stop ? resp : model_result;
      model_result = exp_res;
      checks++;
      if (n_done !== nd0 + 1 || double_done !== 0) begin
         errors++;
         $display("FAIL done_count: got %0d pulses (double=%0d) required 1", n_done - nd0, double_done);
      end
      checks++;
      if (cap_result !== exp_res || cap_err !== exp_err) begin
         errors++;
         $display("FAIL rx_outcome: result=%h err=%b required %h/%b", cap_result, cap_err, exp_res, exp_err);
      end
      checks++;
      if (done_cyc < f + 155 || done_cyc > f + 156) begin
         errors++;
         $display("FAIL rx_timing: done %0d cycles after pin fall, required 155..156", done_cyc - f);
      end
      checks++;
      if (cap_busy !== 1'b1 || after_busy !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_around_done: at=%b after=%b now=%b required 1/0/0", cap_busy, after_busy, busy);
      end
      checks++;
      if (result !== exp_res || err !== exp_err) begin
         errors++;
         $display("FAIL held_outputs: result=%h err=%b required %h/%b", result, err, exp_res, exp_err);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (host_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: tx=%b busy=%b done=%b result=%h err=%b required 1/0/0/00/0", host_tx, busy, done, result, err);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (host_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: tx=%b busy=%b done=%b required 1/0/0", host_tx, busy, done);
      end
   endtask

   task automatic test_basic_send();
      accept_start(8'h12, 8'h34);
      check_tx(8'h12, 8'h34, 1'b0);
      rt_finish(8'h46, 1'b1, 10);
   endtask

   // Timeout; start_in_done=1 pulses start in the done cycle (ignored),
   // otherwise start in the following cycle is accepted and completes.
   task automatic test_timeout(input bit start_in_done);
      int         k;
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      accept_start(a, b);
      check_tx(a, b, 1'b0);
      k = 0;
      while (done !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != TO * B) begin
         errors++;
         $display("FAIL timeout_latency: done after %0d cycles, required %0d", k, TO * B);
      end
      checks++;
      if (err !== 1'b1 || result !== model_result || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_outputs: err=%b result=%h busy=%b required 1/%h/1", err, result, busy, model_result);
      end
      if (start_in_done) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         checks++;
         if (busy !== 1'b0 || host_tx !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL start_in_done_ignored: busy=%b tx=%b err=%b required 0/1/1", busy, host_tx, err);
         end
      end else begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL after_timeout_done: busy=%b err=%b required 0/1", busy, err);
         end
         a = 8'($urandom);
         b = 8'($urandom);
         accept_start(a, b);
         check_tx(a, b, 1'b0);
         rt_finish(8'($urandom), 1'b1, 3);
      end
   endtask

   task automatic test_framing();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      accept_start(a, b);
      check_tx(a, b, 1'b0);
      rt_finish(8'hA5, 1'b0, 7);
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      accept_start(a, b);
      check_tx(a, b, 1'b0);
      rt_finish(8'($urandom), 1'b1, 0);
   endtask

   task automatic test_glitch();
      int         nd0;
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      accept_start(a, b);
      check_tx(a, b, 1'b0);
      nd0 = n_done;
      repeat (5) @(negedge clk);
      host_rx = 1'b0;
      repeat (4) @(negedge clk);
      host_rx = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (n_done !== nd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_rejected: done pulses=%0d busy=%b required 0/1", n_done - nd0, busy);
      end
      rt_finish(8'h3C, 1'b1, 0);
   endtask

   task automatic test_reset_mid();
      int         nd0;
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      accept_start(a, b);
      repeat (3 * B + 5) @(negedge clk);
      checks++;
      if (host_tx !== a[2]) begin
         errors++;
         $display("FAIL op1_bit3: host_tx=%b required %b", host_tx, a[2]);
      end
      nd0 = n_done;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (host_tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: host_tx=%b busy=%b required 1/0", host_tx, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_result = 8'h00;
      repeat (25 * B) @(negedge clk);
      checks++;
      if (n_done !== nd0 || host_tx !== 1'b1 || busy !== 1'b0 || result !== 8'h00) begin
         errors++;
         $display("FAIL abandoned_txn: done pulses=%0d tx=%b busy=%b result=%h required 0/1/0/00", n_done - nd0, host_tx, busy, result);
      end
      a = 8'($urandom);
      b = 8'($urandom);
      accept_start(a, b);
      check_tx(a, b, 1'b1);
      rt_finish(8'($urandom), 1'b1, 5);
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      for (int i = 0; i < 6; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         @(negedge clk);
         accept_start(a, b);
         check_tx(a, b, 1'b1);
         rt_finish(8'($urandom), logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 30)));
      end
   endtask

   initial begin
      test_reset();
      test_basic_send();
      @(negedge clk);
      test_timeout(1'b1);
      test_timeout(1'b0);
      @(negedge clk);
      test_framing();
      @(negedge clk);
      test_glitch();
      @(negedge clk);
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
